// File: rtl/axi4_lite_data_mem_slave_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_data_mem_slave_if
// AXI4-Lite bus bundle between the core's load/store unit (master) and the
// data memory responder (slave).
//   AW channel : awaddr, awprot, awvalid -> / <- awready
//   W  channel : wdata, wstrb, wvalid    -> / <- wready
//   B  channel : <- bresp, bvalid / bready ->
//   AR channel : araddr, arprot, arvalid -> / <- arready
//   R  channel : <- rdata, rresp, rvalid / rready ->
// ---------------------------------------------------------------------------
interface axi4_lite_data_mem_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_data_mem_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_data_mem_slave
// AXI4-Lite responder holding the core's data memory (DEPTH_WORDS x 32 bit).
// Independent read and write engines; byte strobes on writes; OKAY for
// in-range accesses, SLVERR (and rdata=0 on reads) for out-of-range ones.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (memory contents are not reset)
//   s_axi : AXI4-Lite slave modport (AW/W/B/AR/R channels)
// ---------------------------------------------------------------------------
module axi4_lite_data_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axi4_lite_data_mem_slave_if.slave     s_axi
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One extra bit so BASE_ADDR + size cannot wrap at the top of the space.
  localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_ADDR = LO_ADDR + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= LO_ADDR) && ({1'b0, a} < HI_ADDR);
  endfunction

  // addr[1:0] is dropped: accesses are always treated as word aligned.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  // ------------------------------------------------------------ write side
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  w_state_t              w_state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic                  aw_hs, w_hs, wr_commit, wr_in_range;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [IDX_W-1:0]      wr_idx;

  assign aw_hs = s_axi.awvalid & awready_q;
  assign w_hs  = s_axi.wvalid  & wready_q;

  // A channel handshaking this cycle is used directly; otherwise its latch.
  assign wr_addr = aw_held_q ? awaddr_q : s_axi.awaddr;
  assign wr_data = w_held_q  ? wdata_q  : s_axi.wdata;
  assign wr_strb = w_held_q  ? wstrb_q  : s_axi.wstrb;

  assign wr_commit   = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_in_range = addr_in_range(wr_addr);
  assign wr_idx      = word_idx(wr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (wr_commit) begin
            w_state_q <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              awaddr_q  <= s_axi.awaddr;
              awready_q <= 1'b0;
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              wdata_q  <= s_axi.wdata;
              wstrb_q  <= s_axi.wstrb;
              wready_q <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Memory array has no reset; rst_n gating keeps a master that holds
  // valids during reset from writing while the FSM is being cleared.
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit && wr_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ------------------------------------------------------------- read side
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  r_state_t    r_state_q;
  logic        arready_q, rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;
  logic        ar_hs;

  assign ar_hs = s_axi.arvalid & arready_q;

  // mem is sampled with the pre-edge value, so a same-cycle write commit to
  // the same word is not visible to this read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q <= R_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            if (addr_in_range(s_axi.araddr)) begin
              rdata_q <= mem[word_idx(s_axi.araddr)];
              rresp_q <= RESP_OKAY;
            end else begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end
          end
        end
        R_RESP: begin
          if (s_axi.rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  // Protection attributes carry no meaning for this memory.
  logic unused_prot;
  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

endmodule

// File: doc/axi4_lite_data_mem_slave.md
# axi4_lite_data_mem_slave

AXI4-Lite responder that holds the core's data memory. It is the slave end of the load/store path: the core's memory-access logic drives addresses computed by the ALU. This block accepts independent read and write transactions, applies byte strobes, and returns OKAY/SLVERR responses.

## Interface
- ADDR_WIDTH, 32, width of awaddr/araddr
- DEPTH_WORDS, 1024, number of 32-bit memory words; power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH_WORDS

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write byte address
- s_axi_awprot  in  3  accepted, ignored
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i]
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response; 2'b00 OKAY, 2'b10 SLVERR
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read byte address
- s_axi_arprot  in  3  accepted, ignored
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready

## Operation
- Decode: in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS. Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored, and there are no unaligned faults.
- Write FSM states:
  - W_IDLE: AW and W are accepted independently, in either order or in the same cycle. A captured channel latches its payload and drops its ready.
  - When both AW and W are held, the write commits in that cycle and the FSM moves to W_RESP. The commit updates only strobed bytes; wstrb=0 changes nothing and still returns OKAY.
  - W_RESP: bvalid=1, bresp held stable until bready. On the handshake the latches clear and the FSM returns to W_IDLE.
- Out-of-range write: memory is unchanged and bresp=SLVERR.
- Read FSM states:
  - R_IDLE: arready=1. An AR handshake reads memory and registers rdata/rresp, then the FSM moves to R_RESP.
  - R_RESP: rvalid=1, rdata/rresp held stable until rready, then the FSM returns to R_IDLE.
- Out-of-range read: rdata=0, rresp=SLVERR.
- Read and write FSMs are fully independent and may be active in the same cycle.
- Same-cycle write commit and AR handshake to the same word: R returns the pre-write data.
- Once valid is raised, responses never drop before the handshake.
- Memory contents are not reset; words read before their first write are undefined.

## Timing
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0. AW/W latches are cleared.
- Asserting rst_n low mid-transaction aborts it at once: pending AW/W are discarded, no B or R is issued, and memory keeps already-committed writes.
- Write latency: the commit happens in cycle N, when the second of AW/W handshakes; bvalid=1 from N+1.
- With bready=1 at N+1, awready and wready are both 1 again at N+2. Peak rate is 1 write per 2 cycles.
- Either ready may fall one cycle after its own handshake while the other channel is still pending. That ready stays low until the B handshake.
- Read latency: AR handshake in cycle N gives rvalid=1 at N+1. With rready=1 at N+1, arready=1 at N+2. Peak rate is 1 read per 2 cycles.
- Backpressure: bready/rready held low for k cycles keeps bvalid/rvalid and their payloads constant for those k cycles. arready, or awready/wready, stays 0 until one cycle after the handshake.

## Test plan
- Full write, then read: AW+W in the same cycle to 0x10 with wdata=0xDEADBEEF, wstrb=4'hF. Requires bvalid next cycle, bresp=00. AR to 0x10 then gives rvalid one cycle after the handshake, rdata=0xDEADBEEF, rresp=00.
- Strobes and ordering: W first (0x11223344, wstrb=4'b0101) with AW to 0x10 three cycles later. wready must be low until B. A read of 0x10 returns 0xDE22BE44.
- Out of range (DEPTH_WORDS=1024, BASE 0): write to 0x1000 gives bresp=10 and no memory change. Read of 0x1000 gives rdata=0, rresp=10. A read of 0x0FFC still returns its old value.
- Backpressure: bready=0 and rready=0 for 5 cycles. bvalid/rvalid and payloads must stay stable; arready/awready/wready stay 0 until the cycle after the handshakes.
- Concurrency: a write commit of 0xA5A5A5A5 to 0x20 (old value 0x1) in the same cycle as an AR to 0x20. R returns 0x1, and the next read returns 0xA5A5A5A5.
- Reset mid-operation: AW accepted, W pending, then rst_n pulsed low. After release no bvalid appears, all readies are 1, and prior memory contents are intact.
